uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud divider helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; pointers carry a wrap bit so
// full and empty are told apart without a separate occupancy counter.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even parity
// bit between the data bits and the stop bit (11-bit frame instead of 10).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_byte,
  input  logic              tx_byte_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output uart_state_e       dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  // Handshake: tx_byte is taken on a rising edge where tx_byte_valid && tx_ready;
  // tx_ready depends only on buffer occupancy, never on tx_byte_valid.
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rd_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_byte_valid && tx_ready),
    .wr_data (tx_byte),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready = !fifo_full;

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              line_d;
  logic              serial_q;
  logic              busy_q;
  logic              bit_done;

  assign bit_done  = (clk_cnt_q == CNT_LAST);
  assign dbg_state = state_q;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      serial_q  <= line_d;
      busy_q    <= (state_q != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          data_d    = fifo_rd_data;
          clk_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          // Chain straight into the next frame so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rd_data;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current state; registering it adds one cycle of lag.
  always_comb begin
    line_d = 1'b1;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = data_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = ^data_q;
`endif
      default: line_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed bytes feed an expected queue, a line monitor
// decodes every frame on tx_serial and checks it against the queue.
module tb_uart_tx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int CPB      = 100;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
`else
  localparam int NBITS    = 10;
`endif
  localparam int FRAME    = NBITS * CPB;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           tx_byte = 8'h00;
  logic                 tx_byte_valid = 1'b0;
  logic                 tx_ready;
  logic                 tx_serial;
  logic                 tx_busy;
  uart_pkg::uart_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic       exp_par_q[$];
  int         start_q[$];
  bit         mon_busy = 1'b0;

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .tx_ready      (tx_ready),
    .tx_serial     (tx_serial),
    .tx_busy       (tx_busy),
    .dbg_state     (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Driver: called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input logic par, output int acc);
    int n;
    tx_byte       = b;
    tx_byte_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL ready_timeout byte=0x%02h", b);
    end
    exp_q.push_back(b);
    exp_par_q.push_back(par);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
    end
    repeat (5) @(negedge clk);
  endtask

  // Monitor: decode frames cycle by cycle; each bit must hold for CPB cycles.
  initial begin
    logic [NBITS-1:0] bits;
    logic [7:0]       exp_b;
    logic             exp_p;
    int               glitches;
    bit               aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx_serial == 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        bits     = '0;
        glitches = 0;
        aborted  = 1'b0;
        for (int k = 0; k < NBITS && !aborted; k++) begin
          for (int c = 0; c < CPB; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) bits[k] = tx_serial;
            else if (tx_serial !== bits[k]) glitches++;
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_frame actual=0x%02h required=none", bits[8:1]);
          end else begin
            exp_b = exp_q.pop_front();
            exp_p = exp_par_q.pop_front();
            check("frame_byte", int'(bits[8:1]), int'(exp_b));
            check("frame_glitches", glitches, 0);
            check("stop_bit", int'(bits[NBITS-1]), 1);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", int'(bits[9]), int'(exp_p));
`endif
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Directed stimulus
  initial begin
    int acc;
    int acc0;
    int n;
    int cnt;
    int accepts;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("rst_serial", int'(tx_serial), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_state", int'(dbg_state), int'(uart_pkg::IDLE));
    rst_n = 1'b1;

    // Single byte 0x55 straight after reset release
    check("ready_after_release", int'(tx_ready), 1);
    start_q.delete();
    send(8'h55, 1'b0, acc);
    tx_byte_valid = 1'b0;
    cnt = 0;
    n = 0;
    while (n < 2000) begin
      if (tx_busy) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
      n++;
    end
    check("busy_cycles", cnt, FRAME);
    wait_drain(3000);
    check("t1_frames", start_q.size(), 1);
    if (start_q.size() >= 1) check("t1_start_latency", start_q[0] - acc, 2);

    // Four back-to-back bytes
    start_q.delete();
    send(8'hA5, 1'b0, acc0);
    send(8'h3C, 1'b0, acc);
    send(8'hFF, 1'b0, acc);
    send(8'h00, 1'b0, acc);
    tx_byte_valid = 1'b0;
    wait_drain(6000);
    check("t2_frames", start_q.size(), 4);
    if (start_q.size() == 4) begin
      check("t2_start_latency", start_q[0] - acc0, 2);
      for (int i = 1; i < 4; i++) check("t2_frame_gap", start_q[i] - start_q[i-1], FRAME);
    end

    // Fill the buffer with valid held high, then offer 0x77 while not ready
    start_q.delete();
    b = 8'h10;
    accepts = 0;
    tx_byte_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tx_byte = b;
      if (!tx_ready) break;
      exp_q.push_back(b);
      exp_par_q.push_back(^b);
      @(negedge clk);
      accepts++;
      b = b + 8'd1;
    end
    check("fill_accepts", accepts, DEPTH + 1);
    check("fill_ready_low", int'(tx_ready), 0);
    tx_byte = 8'h77;
    repeat (50) @(negedge clk);
    check("ready_still_low", int'(tx_ready), 0);
    tx_byte_valid = 1'b0;
    wait_drain(8000);
    check("t3_frames", start_q.size(), DEPTH + 1);

    // Reset in the middle of a 0x0F frame, then send 0x81
    start_q.delete();
    send(8'h0F, 1'b0, acc);
    tx_byte_valid = 1'b0;
    while (cyc < acc + 2 + 450) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_serial", int'(tx_serial), 1);
    check("abort_busy", int'(tx_busy), 0);
    check("abort_ready", int'(tx_ready), 1);
    check("abort_state", int'(dbg_state), int'(uart_pkg::IDLE));
    exp_q.delete();
    exp_par_q.delete();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) cnt++;
    end
    check("line_high_in_reset", cnt, 0);
    rst_n = 1'b1;
    check("ready_after_abort", int'(tx_ready), 1);
    send(8'h81, 1'b0, acc);
    tx_byte_valid = 1'b0;
    wait_drain(3000);
    check("t4_frames", start_q.size(), 2);
    if (start_q.size() == 2) check("t4_start_latency", start_q[1] - acc, 2);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has three ones, 0x03 has two
    start_q.delete();
    send(8'h07, 1'b1, acc0);
    send(8'h03, 1'b0, acc);
    tx_byte_valid = 1'b0;
    wait_drain(4000);
    check("t5_frames", start_q.size(), 2);
    if (start_q.size() == 2) check("t5_frame_gap", start_q[1] - start_q[0], 1100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
